// File: rtl/riscv_pkg.sv
// Load funct3 encodings, load-unit FSM states and size decode shared by the
// load alignment datapath.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_RESP
  } load_state_e;

  function automatic logic [3:0] load_size(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

  // 111 never decodes; LD and LWU only exist when the datapath is 64 bits wide.
  function automatic logic load_illegal(input logic [2:0] funct3, input int xlen);
    return (funct3 == 3'b111) ||
           ((xlen == 32) && ((funct3 == F3_LD) || (funct3 == F3_LWU)));
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational byte extraction and sign/zero extension from a pair of
// memory words; the generalised byte/half/word/dword load select.
module load_extend #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0]          beats,
  input  logic [$clog2(XLEN/8)-1:0]  offset,
  input  logic [3:0]                 size,
  input  logic                       is_signed,
  output logic [XLEN-1:0]            data
);

  localparam int W = XLEN / 8;

  logic [2*XLEN-1:0] shifted;
  logic              fill;

  always_comb begin
    shifted = beats >> {offset, 3'b000};
    fill    = 1'b0;
    // The fill bit is the top bit of the last byte actually loaded.
    for (int b = 0; b < W; b++) begin
      if (int'(size) == b + 1) fill = is_signed & shifted[8*b+7];
    end
    data = '0;
    for (int b = 0; b < W; b++) begin
      data[8*b +: 8] = (b < int'(size)) ? shifted[8*b +: 8] : {8{fill}};
    end
  end

endmodule

// File: rtl/load_align_unit.sv
// MEM-stage load unit: issues one or two aligned word reads per load request,
// extracts/extends the addressed bytes and returns them with ready/valid.
module load_align_unit
  import riscv_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      req_funct3,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_fault
);

  localparam int W     = XLEN / 8;
  localparam int OFF_W = $clog2(W);

  load_state_e      state_q, state_d;
  logic [XLEN-1:0]  addr_q;
  logic [OFF_W-1:0] off_q;
  logic [3:0]       size_q;
  logic             signed_q;
  logic             split_q;
  logic [XLEN-1:0]  beat0_q;
  logic [XLEN-1:0]  rsp_data_q;
  logic             rsp_fault_q;

  logic [OFF_W-1:0]  req_off;
  logic [3:0]        req_size;
  logic              req_split;
  logic              req_fault;
  logic [2*XLEN-1:0] ext_beats;
  logic [XLEN-1:0]   ext_data;

  always_comb begin
    req_off   = req_addr[OFF_W-1:0];
    req_size  = load_size(req_funct3);
    req_split = (int'(req_off) + int'(req_size)) > W;
    req_fault = load_illegal(req_funct3, XLEN) || (!ALLOW_MISALIGNED && req_split);
  end

  // The second beat arrives live on mem_rdata, so extension runs on the
  // incoming word and the result is registered straight into rsp_data.
  always_comb begin
    if (state_q == ST_WAIT1) ext_beats = {mem_rdata, beat0_q};
    else                     ext_beats = {{XLEN{1'b0}}, mem_rdata};
  end

  load_extend #(.XLEN(XLEN)) u_extend (
    .beats     (ext_beats),
    .offset    (off_q),
    .size      (size_q),
    .is_signed (signed_q),
    .data      (ext_data)
  );

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    rsp_valid     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_fault ? ST_RESP : ST_REQ0;
      end
      ST_REQ0: begin
        mem_req_valid = 1'b1;
        mem_addr      = addr_q;
        if (mem_req_ready) state_d = ST_WAIT0;
      end
      ST_WAIT0: begin
        if (mem_rvalid) state_d = split_q ? ST_REQ1 : ST_RESP;
      end
      ST_REQ1: begin
        mem_req_valid = 1'b1;
        mem_addr      = addr_q + XLEN'(W);
        if (mem_req_ready) state_d = ST_WAIT1;
      end
      ST_WAIT1: begin
        if (mem_rvalid) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      off_q       <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      split_q     <= 1'b0;
      beat0_q     <= '0;
      rsp_data_q  <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid) begin
        addr_q      <= {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
        off_q       <= req_off;
        size_q      <= req_size;
        signed_q    <= ~req_funct3[2];
        split_q     <= req_split;
        rsp_fault_q <= req_fault;
        rsp_data_q  <= '0;
      end
      if (state_q == ST_WAIT0 && mem_rvalid) begin
        beat0_q <= mem_rdata;
        if (!split_q) rsp_data_q <= ext_data;
      end
      if (state_q == ST_WAIT1 && mem_rvalid) begin
        rsp_data_q <= ext_data;
      end
    end
  end

  assign rsp_data  = rsp_data_q;
  assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench: XLEN=32 (misaligned split and fault variants) and XLEN=64
// units share one clock and one word-addressed memory model.
module tb_load_align_unit;
  import riscv_pkg::*;

  logic        clk           = 1'b0;
  logic        rst_n         = 1'b0;
  logic [2:0]  req_valid     = '0;
  logic [63:0] req_addr      = '0;
  logic [2:0]  req_funct3    = '0;
  logic        mem_req_ready = 1'b1;
  logic        rsp_ready     = 1'b1;
  logic [2:0]  mem_rvalid    = '0;
  logic [63:0] mem_rdata     = '0;
  logic        mem_stall     = 1'b0;
  logic [2:0]  inject_rv     = '0;

  logic [2:0]  req_ready, mem_req_valid, rsp_valid, rsp_fault;
  logic [31:0] maddr0, maddr1, rdata0, rdata1;
  logic [63:0] maddr2, rdata2;
  logic [63:0] mem_addr_a [3];
  logic [63:0] rsp_data_a [3];

  logic [63:0] mem [logic [63:0]];
  logic [63:0] rd_log [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_align_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) d32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[31:0]), .req_funct3(req_funct3),
    .mem_req_valid(mem_req_valid[0]), .mem_req_ready(mem_req_ready),
    .mem_addr(maddr0), .mem_rvalid(mem_rvalid[0]), .mem_rdata(mem_rdata[31:0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
    .rsp_data(rdata0), .rsp_fault(rsp_fault[0])
  );

  load_align_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) d32n (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[31:0]), .req_funct3(req_funct3),
    .mem_req_valid(mem_req_valid[1]), .mem_req_ready(mem_req_ready),
    .mem_addr(maddr1), .mem_rvalid(mem_rvalid[1]), .mem_rdata(mem_rdata[31:0]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
    .rsp_data(rdata1), .rsp_fault(rsp_fault[1])
  );

  load_align_unit #(.XLEN(64), .ALLOW_MISALIGNED(1'b1)) d64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr), .req_funct3(req_funct3),
    .mem_req_valid(mem_req_valid[2]), .mem_req_ready(mem_req_ready),
    .mem_addr(maddr2), .mem_rvalid(mem_rvalid[2]), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready),
    .rsp_data(rdata2), .rsp_fault(rsp_fault[2])
  );

  always_comb begin
    mem_addr_a[0] = {32'h0, maddr0};
    mem_addr_a[1] = {32'h0, maddr1};
    mem_addr_a[2] = maddr2;
    rsp_data_a[0] = {32'h0, rdata0};
    rsp_data_a[1] = {32'h0, rdata1};
    rsp_data_a[2] = rdata2;
  end

  // Memory answers each accepted read one cycle later unless stalled.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      mem_rvalid[k] <= inject_rv[k];
      if (mem_req_valid[k] && mem_req_ready) begin
        rd_log.push_back(mem_addr_a[k]);
        if (!mem_stall) begin
          mem_rvalid[k] <= 1'b1;
          mem_rdata     <= mem.exists(mem_addr_a[k]) ? mem[mem_addr_a[k]] : 64'h0;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int k, input logic [63:0] addr, input logic [2:0] f3,
                         output logic [63:0] data, output logic fault, output int lat);
    req_addr      = addr;
    req_funct3    = f3;
    req_valid[k]  = 1'b1;
    tick();
    req_valid[k]  = 1'b0;
    lat = 0;
    while (!rsp_valid[k] && lat < 40) begin
      tick();
      lat++;
    end
    data  = rsp_data_a[k];
    fault = rsp_fault[k];
    tick();
  endtask

  task automatic run_load(input string tag, input int k, input logic [63:0] addr,
                          input logic [2:0] f3, input logic [63:0] exp_data,
                          input logic exp_fault, input int exp_lat, input int exp_reads,
                          input logic [63:0] exp_a0, input logic [63:0] exp_a1);
    logic [63:0] data;
    logic        fault;
    int          lat;
    rd_log.delete();
    do_load(k, addr, f3, data, fault, lat);
    check_eq({tag, "_data"}, data, exp_data);
    check_eq({tag, "_fault"}, 64'(fault), 64'(exp_fault));
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_reads"}, 64'(rd_log.size()), 64'(exp_reads));
    for (int i = 0; i < exp_reads && i < rd_log.size(); i++)
      check_eq({tag, "_addr"}, rd_log[i], (i == 0) ? exp_a0 : exp_a1);
    check_eq({tag, "_idle"}, 64'(req_ready[k]), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int n;

    // Reset values while held in reset
    tick();
    check_eq("rst_req_ready", 64'(req_ready), 64'h7);
    check_eq("rst_mem_req_valid", 64'(mem_req_valid), 64'h0);
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check_eq("rst_rsp_fault", 64'(rsp_fault), 64'h0);
    check_eq("rst_mem_addr", mem_addr_a[2], 64'h0);
    check_eq("rst_rsp_data", rsp_data_a[0], 64'h0);
    rst_n = 1'b1;
    tick();

    // Byte loads from one word, signed and unsigned
    mem[64'h1000] = 64'h12345680;
    run_load("lb0",  0, 64'h1000, F3_LB,  64'hFFFFFF80, 1'b0, 2, 1, 64'h1000, 64'h0);
    run_load("lbu0", 0, 64'h1000, F3_LBU, 64'h00000080, 1'b0, 2, 1, 64'h1000, 64'h0);
    run_load("lb1",  0, 64'h1001, F3_LB,  64'h00000056, 1'b0, 2, 1, 64'h1000, 64'h0);

    // Word-crossing halfword: split vs. fault
    mem[64'h1000] = 64'hAABBCCDD;
    mem[64'h1004] = 64'h11223344;
    run_load("lh_split", 0, 64'h1003, F3_LH, 64'h000044AA, 1'b0, 4, 2, 64'h1000, 64'h1004);
    run_load("lh_nomis", 1, 64'h1003, F3_LH, 64'h0,        1'b1, 0, 0, 64'h0,    64'h0);

    // Illegal funct3 on XLEN=32
    run_load("f3_111", 0, 64'h1000, 3'b111, 64'h0, 1'b1, 0, 0, 64'h0, 64'h0);
    run_load("f3_ld32", 0, 64'h1000, F3_LD, 64'h0, 1'b1, 0, 0, 64'h0, 64'h0);
    run_load("f3_lwu32", 0, 64'h1000, F3_LWU, 64'h0, 1'b1, 0, 0, 64'h0, 64'h0);

    // XLEN=64 loads
    mem[64'h2000] = 64'h8877665544332211;
    mem[64'h2008] = 64'h00000000FFEEDDCC;
    run_load("ld64",  2, 64'h2004, F3_LD,  64'hFFEEDDCC88776655, 1'b0, 4, 2, 64'h2000, 64'h2008);
    run_load("lwu64", 2, 64'h2004, F3_LWU, 64'h0000000088776655, 1'b0, 2, 1, 64'h2000, 64'h0);
    run_load("lh64",  2, 64'h2006, F3_LH,  64'hFFFFFFFFFFFF8877, 1'b0, 2, 1, 64'h2000, 64'h0);
    run_load("f3_111_64", 2, 64'h2000, 3'b111, 64'h0, 1'b1, 0, 0, 64'h0, 64'h0);

    // Memory-side backpressure
    rd_log.delete();
    mem_req_ready = 1'b0;
    req_addr      = 64'h1000;
    req_funct3    = F3_LW;
    req_valid[0]  = 1'b1;
    tick();
    req_valid[0]  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_mreq_valid", 64'(mem_req_valid[0]), 64'd1);
      check_eq("bp_mem_addr", mem_addr_a[0], 64'h1000);
      check_eq("bp_req_ready", 64'(req_ready[0]), 64'd0);
      tick();
    end
    check_eq("bp_mreq_still", 64'(mem_req_valid[0]), 64'd1);
    check_eq("bp_no_reads", 64'(rd_log.size()), 64'd0);

    // Response-side backpressure
    mem_req_ready = 1'b1;
    rsp_ready     = 1'b0;
    n = 0;
    while (!rsp_valid[0] && n < 40) begin
      tick();
      n++;
    end
    check_eq("bp_rsp_lat", 64'(n), 64'd2);
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_rsp_valid", 64'(rsp_valid[0]), 64'd1);
      check_eq("bp_rsp_data", rsp_data_a[0], 64'hAABBCCDD);
      check_eq("bp_rsp_req_ready", 64'(req_ready[0]), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check_eq("bp_done_req_ready", 64'(req_ready[0]), 64'd1);
    check_eq("bp_done_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    check_eq("bp_reads", 64'(rd_log.size()), 64'd1);

    // Reset while waiting for the second beat
    rd_log.delete();
    req_addr     = 64'h1003;
    req_funct3   = F3_LH;
    req_valid[0] = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    n = 0;
    while (!(mem_req_valid[0] && mem_addr_a[0] == 64'h1004) && n < 40) begin
      tick();
      n++;
    end
    check_eq("w1_reach", 64'(n), 64'd2);
    mem_stall = 1'b1;
    tick();
    check_eq("w1_mreq_valid", 64'(mem_req_valid[0]), 64'd0);
    check_eq("w1_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    check_eq("w1_req_ready", 64'(req_ready[0]), 64'd0);
    rst_n = 1'b0;
    #1;
    check_eq("arst_req_ready", 64'(req_ready[0]), 64'd1);
    check_eq("arst_mreq_valid", 64'(mem_req_valid[0]), 64'd0);
    check_eq("arst_mem_addr", mem_addr_a[0], 64'h0);
    check_eq("arst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    check_eq("arst_rsp_data", rsp_data_a[0], 64'h0);
    check_eq("arst_rsp_fault", 64'(rsp_fault[0]), 64'd0);
    tick();
    tick();
    rst_n     = 1'b1;
    mem_stall = 1'b0;
    tick();
    inject_rv[0] = 1'b1;
    tick();
    inject_rv[0] = 1'b0;
    tick();
    tick();
    check_eq("stale_rsp_valid", 64'(rsp_valid[0]), 64'd0);
    check_eq("stale_req_ready", 64'(req_ready[0]), 64'd1);
    check_eq("stale_mreq_valid", 64'(mem_req_valid[0]), 64'd0);
    run_load("lw_after_rst", 0, 64'h1000, F3_LW, 64'hAABBCCDD, 1'b0, 2, 1, 64'h1000, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
